// File: rtl/contador_prog.sv
// Programmable up/down counter with a prescaler, a terminal-count pulse,
// a sticky one-shot mode, and LEDs driven by the top bits of the count.
module contador_prog #(
  parameter int N     = 28,
  parameter int PRESC = 1,
  parameter int NLEDS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [N-1:0]     load_val,
  input  logic [N-1:0]     modulo,
  input  logic             oneshot,
  output logic [N-1:0]     count,
  output logic             tc,
  output logic             done,
  output logic [NLEDS-1:0] leds
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
  localparam logic [PW-1:0] PONE  = PW'(1);
  localparam logic [N-1:0]  ONE   = N'(1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [N-1:0]  count_q, count_d;
  logic          tc_q, tc_d;
  logic          done_q, done_d;
  logic          tick;
  logic          terminal;

  always_comb begin
    tick     = en & ~done_q & (pcnt_q == PLAST);
    // Up direction treats anything at or above modulo as terminal.
    terminal = up ? (count_q >= modulo) : (count_q == '0);

    pcnt_d  = pcnt_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (load) begin
      count_d = load_val;
      pcnt_d  = '0;
      done_d  = 1'b0;
    end else if (en && !done_q) begin
      if (tick) begin
        pcnt_d = '0;
        if (terminal) begin
          tc_d = 1'b1;
          if (oneshot) begin
            count_d = up ? modulo : '0;
            done_d  = 1'b1;
          end else begin
            count_d = up ? '0 : modulo;
          end
        end else begin
          count_d = up ? (count_q + ONE) : (count_q - ONE);
        end
      end else begin
        pcnt_d = pcnt_q + PONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign leds  = count_q[N-1 -: NLEDS];

endmodule

// File: tb/tb_contador_prog.sv
// Randomized and directed bench for contador_prog: two instances (prescale 1
// and 4) share inputs and are compared every cycle with an arithmetic model.
module tb_contador_prog;

  localparam int N  = 8;
  localparam int NL = 3;

  logic         clk = 1'b0;
  logic         rst, en, up, load, oneshot;
  logic [N-1:0] load_val, modulo;

  logic [N-1:0]  count_a, count_b;
  logic          tc_a, tc_b, done_a, done_b;
  logic [NL-1:0] leds_a, leds_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int presc[2] = '{1, 4};
  int m_pc[2], m_cnt[2], m_tc[2], m_dn[2];

  always #5 clk = ~clk;

  contador_prog #(.N(N), .PRESC(1), .NLEDS(NL)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .modulo(modulo), .oneshot(oneshot), .count(count_a), .tc(tc_a),
    .done(done_a), .leds(leds_a)
  );

  contador_prog #(.N(N), .PRESC(4), .NLEDS(NL)) u_p4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .modulo(modulo), .oneshot(oneshot), .count(count_b), .tc(tc_b),
    .done(done_b), .leds(leds_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour for instance k.
  task automatic model_step(input int k);
    int m;
    bit term;
    m = int'(modulo);
    if (rst) begin
      m_pc[k] = 0; m_cnt[k] = 0; m_tc[k] = 0; m_dn[k] = 0;
    end else if (load) begin
      m_cnt[k] = int'(load_val); m_pc[k] = 0; m_dn[k] = 0; m_tc[k] = 0;
    end else if (en && m_dn[k] == 0) begin
      m_tc[k] = 0;
      if (m_pc[k] == presc[k] - 1) begin
        m_pc[k] = 0;
        term = up ? (m_cnt[k] >= m) : (m_cnt[k] == 0);
        if (term) begin
          m_tc[k] = 1;
          if (oneshot) begin
            m_cnt[k] = up ? m : 0;
            m_dn[k]  = 1;
          end else begin
            m_cnt[k] = up ? 0 : m;
          end
        end else begin
          m_cnt[k] = up ? (m_cnt[k] + 1) % 256 : (m_cnt[k] + 255) % 256;
        end
      end else begin
        m_pc[k] = m_pc[k] + 1;
      end
    end else begin
      m_tc[k] = 0;
    end
  endtask

  task automatic check_all();
    check_eq("p1_count", 32'(count_a), 32'(m_cnt[0]));
    check_eq("p1_tc",    32'(tc_a),    32'(m_tc[0]));
    check_eq("p1_done",  32'(done_a),  32'(m_dn[0]));
    check_eq("p1_leds",  32'(leds_a),  32'(m_cnt[0] >> (N - NL)));
    check_eq("p4_count", 32'(count_b), 32'(m_cnt[1]));
    check_eq("p4_tc",    32'(tc_b),    32'(m_tc[1]));
    check_eq("p4_done",  32'(done_b),  32'(m_dn[1]));
    check_eq("p4_leds",  32'(leds_b),  32'(m_cnt[1] >> (N - NL)));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int e32c[7] = '{1, 2, 3, 4, 5, 0, 1};
    int e32t[7] = '{0, 0, 0, 0, 0, 1, 0};
    int e33c[12] = '{2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 3};
    int e34c[6] = '{1, 2, 3, 3, 3, 3};
    int e34t[6] = '{0, 0, 0, 1, 0, 0};
    int e34d[6] = '{0, 0, 0, 1, 1, 1};

    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; oneshot = 1'b0;
    load_val = '0; modulo = 8'd5;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_cnt[k] = 0; m_tc[k] = 0; m_dn[k] = 0;
    end
    step();
    check_eq("reset_count", 32'(count_a), 0);
    check_eq("reset_done",  32'(done_b), 0);

    // Free-running up count, modulo 5.
    en = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("seq32_count", 32'(count_a), 32'(e32c[i]));
      check_eq("seq32_tc",    32'(tc_a),    32'(e32t[i]));
    end

    // Prescaled down count after a load.
    modulo = 8'd3; up = 1'b0; load_val = 8'd2; load = 1'b1;
    step();
    check_eq("seq33_load", 32'(count_b), 2);
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("seq33_count", 32'(count_b), 32'(e33c[i]));
      check_eq("seq33_tc",    32'(tc_b),    32'(i == 11));
    end

    // One-shot up to 3, then done is sticky until a load.
    up = 1'b1; oneshot = 1'b1; modulo = 8'd3;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("seq34_count", 32'(count_a), 32'(e34c[i]));
      check_eq("seq34_tc",    32'(tc_a),    32'(e34t[i]));
      check_eq("seq34_done",  32'(done_a),  32'(e34d[i]));
    end
    oneshot = 1'b0; up = 1'b0;
    repeat (3) step();
    check_eq("done_sticky", 32'(done_a), 1);
    load_val = 8'd0; load = 1'b1; up = 1'b1;
    step();
    check_eq("done_clear", 32'(done_a), 0);
    load = 1'b0;
    step();
    check_eq("restart_count", 32'(count_a), 1);

    // Load beats a coincident tick; reset beats load.
    load_val = 8'h80; load = 1'b1;
    step();
    check_eq("load_prio_count", 32'(count_a), 32'h80);
    check_eq("load_prio_tc",    32'(tc_a), 0);
    rst = 1'b1;
    step();
    check_eq("rst_prio_count", 32'(count_a), 0);
    rst = 1'b0; load = 1'b0;

    // Count above modulo going up wraps at once; modulo 0 pulses every tick.
    modulo = 8'd10; load_val = 8'd200; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check_eq("above_mod_count", 32'(count_a), 0);
    check_eq("above_mod_tc",    32'(tc_a), 1);
    modulo = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("mod0_count", 32'(count_a), 0);
      check_eq("mod0_tc",    32'(tc_a), 1);
    end

    // LEDs follow the top bits; reset clears them on the next edge.
    modulo = 8'd255;
    do_reset();
    repeat (32) step();
    check_eq("leds_one", 32'(leds_a), 1);
    rst = 1'b1;
    step();
    check_eq("leds_rst", 32'(leds_a), 0);
    rst = 1'b0;

    // Randomized traffic.
    modulo = 8'd7;
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom % 80) == 0;
      load = ($urandom % 20) == 0;
      en   = ($urandom % 8) != 0;
      if (($urandom % 8) == 0)  up = ~up;
      if (($urandom % 40) == 0) oneshot = ~oneshot;
      if (($urandom % 50) == 0)
        modulo = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % 12);
      load_val = (($urandom % 3) != 0) ? 8'($urandom % 16) : 8'($urandom % 256);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/contador_prog.md
CONTADOR_PROG -- requirements
Module: contador_prog

Interface
REQ-001 Parameter N, default 28, counter width in bits (N >= 2).
REQ-002 Parameter PRESC, default 1, prescaler division ratio (PRESC >= 1); 1 means a count step every enabled cycle.
REQ-003 Parameter NLEDS, default 5, number of LED outputs (1 <= NLEDS <= N).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  count enable; gates the prescaler.
REQ-007 up  input  1  direction: 1 = up, 0 = down; sampled on every tick.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  N  value written to count on load.
REQ-010 modulo  input  N  terminal value; count range is 0..modulo.
REQ-011 oneshot  input  1  mode: 0 = free-running wrap, 1 = stop at first terminal event.
REQ-012 count  output  N  current counter value, registered.
REQ-013 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-014 done  output  1  one-shot completion flag, registered, sticky.
REQ-015 leds  output  NLEDS  count[N-1 : N-NLEDS].

Function
REQ-016 Prescaler register pcnt (width clog2(PRESC), min 1 bit) shall advance only when en=1 and done=0; tick = en & ~done & (pcnt == PRESC-1); on tick pcnt wraps to 0.
REQ-017 With en=0, pcnt, count, done shall hold; tc shall be 0.
REQ-018 Up step on tick: if count >= modulo -> count <= 0 and tc <= 1; else count <= count+1, tc <= 0.
REQ-019 Down step on tick: if count == 0 -> count <= modulo and tc <= 1; else count <= count-1, tc <= 0.
REQ-020 modulo = 0: count shall remain 0 and tc shall pulse on every tick (free-running mode).
REQ-021 Count above modulo (via load or modulo change): up direction treats it as terminal (wrap to 0, tc=1); down direction decrements normally.
REQ-022 Latency: count and tc update on the clock edge that samples the tick; tc is high in exactly the cycle count shows the wrapped value.
REQ-023 oneshot=1: on the terminal event count shall hold the terminal value (modulo when up, 0 when down) instead of wrapping, tc shall pulse once, done shall set on the same edge.
REQ-024 While done=1 no further ticks or tc pulses shall occur, regardless of en, up or oneshot changes.
REQ-025 done shall clear only on load or rst; clearing oneshot does not clear done.
REQ-026 load=1 (without rst): count <= load_val, pcnt <= 0, done <= 0, tc <= 0; load takes priority over a coincident tick.
REQ-027 Changing up mid-count shall take effect on the next tick with no extra cycle of delay.
REQ-028 tc shall never be high on two consecutive cycles unless PRESC = 1 and the terminal condition recurs (modulo = 0, or up/down toggling).
REQ-029 All arithmetic is modulo 2^N; no output shall depend combinationally on inputs except leds on count.

Reset
REQ-030 rst=1 has priority over load and tick; on the following edge count=0, pcnt=0, tc=0, done=0, leds=0.
REQ-031 Reset asserted mid-prescale or mid-oneshot shall abandon the operation completely; counting resumes from 0 with a full PRESC period after rst deasserts, if en=1.

Verification
REQ-032 N=8, PRESC=1, modulo=5, up=1, oneshot=0, en=1 after rst -> count 0,1,2,3,4,5,0,1...; tc=1 only in cycles where count returns to 0.
REQ-033 N=8, PRESC=4, modulo=3, up=0, load_val=2 with load -> count 2 held 4 cycles, then 1, 0, 3 (tc=1 with 3), 2...
REQ-034 oneshot=1, modulo=3, up=1, PRESC=1 -> count 0,1,2,3 then holds 3; tc single pulse, done=1 stays; load with load_val=0 clears done, counting restarts.
REQ-035 load and tick in same cycle with load_val=0x80 -> count=0x80, tc=0; rst and load together -> count=0.
REQ-036 up=1, modulo=10, load_val=200 -> next tick count=0, tc=1; then modulo=0 -> count stays 0, tc pulses each tick.
REQ-037 Default parameters, en=1 for 2^23 cycles after rst -> leds=1 (count=0x0800000), rst mid-run -> leds=0 next cycle.
